bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the count-one FSM stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line that directly drives the FSM's `in` input. Idle and gap cycles present a constant 0, so downstream "consecutive ones" detection never spans a word gap.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `LSB_FIRST`, 0: 0 shifts the MSB out first; 1 shifts the LSB out first.
- `GAP_CYCLES`, 0: forced-zero idle cycles inserted after every word; legal range 0..15.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `data_in` input WIDTH: word to serialize; sampled on handshake.
- `valid_in` input 1: `data_in` is valid.
- `ready_out` output 1: block can accept a word this cycle.
- `out` output 1: serial bit; feeds the downstream FSM `in`.
- `out_valid` output 1: `out` carries a data bit this cycle.
- `frame_start` output 1: high during the first bit of a word.
- `frame_end` output 1: high during the last bit of a word.

## Operation
- States:
  - IDLE: waiting for a word.
  - SHIFT: emitting bits; `bit_cnt` runs 0..WIDTH-1.
  - GAP: forced-zero cycles; `gap_cnt` runs 0..GAP_CYCLES-1.
- Handshake: a transfer occurs on a rising edge where `valid_in && ready_out`. `data_in` is ignored at all other times.
- `ready_out` is high in IDLE. With GAP_CYCLES=0, it is also high in SHIFT when `bit_cnt==WIDTH-1` (back-to-back reload). It is low otherwise and low while `rst` is high.
- On transfer:
  - Load `shreg`, clear `bit_cnt`, enter SHIFT.
  - The first bit is MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1).
- SHIFT:
  - Each cycle, `out` shows the current head bit of `shreg`.
  - At the edge, shift by one and increment `bit_cnt`.
- At `bit_cnt==WIDTH-1`, the edge transition is:
  - transfer occurring → reload and stay in SHIFT;
  - else GAP_CYCLES>0 → GAP;
  - else → IDLE.
- GAP:
  - `out`=0, `out_valid`=0.
  - After GAP_CYCLES cycles, go to IDLE.
- Output decode (all from registers, no combinational path from `valid_in`/`data_in` to `out`):
  - `out_valid` = (state==SHIFT).
  - `frame_start` = SHIFT && `bit_cnt`==0.
  - `frame_end` = SHIFT && `bit_cnt`==WIDTH-1.
  - `out` is forced to 0 whenever `out_valid`=0.
- Illegal state encoding → IDLE on the next edge; outputs are 0 meanwhile.
- Reset values:
  - state IDLE; `shreg`, `bit_cnt`, `gap_cnt` = 0.
  - `out`=0, `out_valid`=0, `frame_start`=0, `frame_end`=0, `ready_out`=0.
- Reset mid-word: the in-flight word is discarded with no partial completion. `out` is 0 in the first cycle after the reset edge.
- `valid_in` dropping while `ready_out`=0 has no effect; the word is not captured.

## Timing
- Latency: a word accepted at edge k has its first bit on `out` in cycle k+1 and its last bit in cycle k+WIDTH.
- Throughput:
  - one word per WIDTH cycles with GAP_CYCLES=0 and `valid_in` held high, with no bubble;
  - one word per WIDTH+GAP_CYCLES+1 cycles otherwise, because the IDLE cycle is needed to re-accept.
- `ready_out` rises in the cycle after the word's last GAP cycle (or its last bit), never earlier.
- `rst` has priority over a simultaneous handshake; the word is not accepted.

## Test plan
- Reset held for 3 cycles with `valid_in`=1 → all outputs 0 and no capture. After release, `ready_out`=1 in IDLE.
- WIDTH=8, LSB_FIRST=0, word 8'hB6 → `out` = 1,0,1,1,0,1,1,0 over 8 cycles. `frame_start` on cycle 1, `frame_end` on cycle 8, then `out`=0 and `out_valid`=0.
- LSB_FIRST=1, words 8'hB6 then 8'h01 with `valid_in` held high → 0,1,1,0,1,1,0,1, then 1,0,0,0,0,0,0,0. This is 16 contiguous valid cycles, and `ready_out` is high only on bit 8 of the first word.
- GAP_CYCLES=2, two back-to-back words 8'hFF → 8 ones, 2 forced zeros, 1 IDLE zero, then 8 ones. The downstream FSM `out` must drop between words.
- `rst` asserted at `bit_cnt`=3 of 8'hF0 → `out`=0 the next cycle and state IDLE. The next word 8'h80 is serialized correctly from its first bit.
- `valid_in` pulsed while in SHIFT, not at the last bit → pulse ignored; the current word completes unchanged.

Source files
------------

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end for the count-one FSM stage. Words are accepted
// over a valid/ready handshake and shifted out one bit per clock. Idle and gap
// cycles present a constant 0, so a run of ones never spans a word boundary.
//
// Parameters:
//   WIDTH       word width in bits (2..32)
//   LSB_FIRST   0: MSB shifted out first, 1: LSB shifted out first
//   GAP_CYCLES  forced-zero cycles inserted after every word (0..15)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   data_in      word to serialize, sampled on handshake
//   valid_in     data_in is valid
//   ready_out    block can accept a word this cycle
//   out          serial bit (0 whenever out_valid is low)
//   out_valid    out carries a data bit this cycle
//   frame_start  first bit of a word
//   frame_end    last bit of a word
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
    localparam logic [GAP_W-1:0] LAST_GAP = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic is_last;
    logic head_bit;
    logic xfer;

    assign is_last  = (bit_cnt_q == LAST_BIT);
    assign head_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign xfer     = valid_in && ready_out;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (LSB_FIRST) begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
                bit_cnt_d = bit_cnt_q + CNT_W'(1);

                if (is_last) begin
                    // Back-to-back reload only possible when ready is up here (no gap).
                    if (xfer) begin
                        state_d   = ST_SHIFT;
                        shreg_d   = data_in;
                        bit_cnt_d = '0;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // Output decode from registered state only; illegal encodings decode to all-zero.
    always_comb begin
        ready_out   = 1'b0;
        out         = 1'b0;
        out_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_out = !rst;
            end

            ST_SHIFT: begin
                out_valid   = 1'b1;
                out         = head_bit;
                frame_start = (bit_cnt_q == '0);
                frame_end   = is_last;
                ready_out   = !rst && (GAP_CYCLES == 0) && is_last;
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Three serializer instances (MSB-first, LSB-first, MSB-first with 2 gap
// cycles) share clk/rst/data_in. Accepted words push their expected per-cycle
// output trace into a scoreboard queue; a negedge monitor pops one entry per
// cycle for the active instance and expects the idle pattern everywhere else.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    typedef struct packed {
        logic ov;
        logic o;
        logic fs;
        logic fe;
        logic rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic [2:0] vin;
    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] ov;
    logic [2:0] fs;
    logic [2:0] fe;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   act   = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vin[0]),
        .ready_out(rdy[0]), .out(so[0]), .out_valid(ov[0]),
        .frame_start(fs[0]), .frame_end(fe[0])
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vin[1]),
        .ready_out(rdy[1]), .out(so[1]), .out_valid(ov[1]),
        .frame_start(fs[1]), .frame_end(fe[1])
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vin[2]),
        .ready_out(rdy[2]), .out(so[2]), .out_valid(ov[2]),
        .frame_start(fs[2]), .frame_end(fe[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_lsb(input int d);
        return d == 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    // Expected per-cycle trace for one accepted word, including its gap cycles.
    task automatic push_word(input int d, input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.ov  = 1'b1;
            e.o   = is_lsb(d) ? w[i] : w[7-i];
            e.fs  = (i == 0);
            e.fe  = (i == 7);
            e.rdy = (i == 7) && (gap_of(d) == 0);
            sb.push_back(e);
        end
        for (int g = 0; g < gap_of(d); g++) begin
            e = '0;
            sb.push_back(e);
        end
    endtask

    // Hold valid with word w until instance d accepts it; returns the accept cycle.
    task automatic send(input int d, input logic [7:0] w, output int acc_cyc);
        bit got;
        got     = 1'b0;
        acc_cyc = -1;
        data_in = w;
        vin[d]  = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                @(posedge clk);
                acc_cyc = cyc;
                push_word(d, w);
                got = 1'b1;
                #1;
            end
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: active instance follows the scoreboard, others stay idle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (d == act && sb.size() > 0) begin
                mon_e = sb.pop_front();
            end else begin
                mon_e     = '0;
                mon_e.rdy = !rst;
            end
            chk($sformatf("d%0d_out_valid", d), 32'(ov[d]),  32'(mon_e.ov));
            chk($sformatf("d%0d_out", d),       32'(so[d]),  32'(mon_e.o));
            chk($sformatf("d%0d_frame_start", d), 32'(fs[d]), 32'(mon_e.fs));
            chk($sformatf("d%0d_frame_end", d), 32'(fe[d]),  32'(mon_e.fe));
            chk($sformatf("d%0d_ready", d),     32'(rdy[d]), 32'(mon_e.rdy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;

        // Reset held 3 cycles with valid high: no capture, all outputs low.
        rst     = 1'b1;
        vin     = 3'b111;
        data_in = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vin = 3'b000;
        repeat (2) @(posedge clk);
        #1;

        // MSB-first single word.
        act = 0;
        send(0, 8'hB6, c1);
        vin[0] = 1'b0;
        drain();

        // Valid pulse mid-word must be ignored.
        send(0, 8'h3C, c1);
        vin[0] = 1'b0;
        @(posedge clk); #1;
        data_in = 8'h55;
        vin[0]  = 1'b1;
        @(posedge clk); #1;
        vin[0]  = 1'b0;
        drain();

        // LSB-first back-to-back with valid held: reload on the last bit.
        act = 1;
        send(1, 8'hB6, c1);
        send(1, 8'h01, c2);
        vin[1] = 1'b0;
        chk("lsb_b2b_spacing", 32'(c2 - c1), 32'd8);
        drain();

        // Two gap cycles plus one idle cycle between words.
        act = 2;
        send(2, 8'hFF, c1);
        send(2, 8'hFF, c2);
        vin[2] = 1'b0;
        chk("gap_spacing", 32'(c2 - c1), 32'd11);
        drain();

        // Reset during bit_cnt==3 of 8'hF0 discards the word.
        act = 0;
        send(0, 8'hF0, c1);
        vin[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h80, c1);
        vin[0] = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
